i2c_slave: RTL and testbench

//  I2C target (responder) for the i2c_master on the same bus: 7-bit addressing, single- and multi-byte writes/reads.

---
 rtl/i2c_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with 7-bit addressing, oversampled SCL/SDA and open-drain SDA
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   scl_steady_high;
  logic                   start_det, stop_det;

  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] byte_in;
  logic       drive_low, drive_n;
  logic       byte_done, byte_done_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, rw_n, busy_n;

  // Open-drain: only ever pull low or let the bus float to its pull-up.
  assign sda = drive_low ? 1'b0 : 1'bz;

  // Synchronise the bus pins and keep one extra delayed copy for edge detection.
  // Reset to the idle-bus level so leaving reset does not fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign sda_rise = sda_s & ~sda_d;
  assign sda_fall = ~sda_s & sda_d;

  // START/STOP only count when SCL was high on both samples, so an SDA edge
  // coinciding with an SCL edge is treated as ordinary data movement.
  assign scl_steady_high = scl_s & scl_d;
  assign start_det       = sda_fall & scl_steady_high;
  assign stop_det        = sda_rise & scl_steady_high;

  // Byte as it will look once the bit being sampled now is shifted in.
  assign byte_in = {shift[6:0], sda_s};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shift     <= 8'h00;
      drive_low <= 1'b0;
      byte_done <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      drive_low <= drive_n;
      byte_done <= byte_done_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      rw        <= rw_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output logic; bus conditions override every state.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shift_n     = shift;
    drive_n     = drive_low;
    byte_done_n = byte_done;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    rw_n        = rw;
    busy_n      = busy;

    if (stop_det) begin
      state_n     = IDLE;
      drive_n     = 1'b0;
      busy_n      = 1'b0;
      byte_done_n = 1'b0;
    end else if (start_det) begin
      state_n     = ADDR;
      cnt_n       = 3'd0;
      drive_n     = 1'b0;
      busy_n      = 1'b0;
      byte_done_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drive_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise && !byte_done) begin
            shift_n = byte_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_n        = byte_in[0];
                busy_n      = 1'b1;
                byte_done_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end else if (scl_fall && byte_done) begin
            drive_n     = 1'b1;
            byte_done_n = 1'b0;
            state_n     = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          // The only falling edge seen here is the one ending the ACK clock.
          if (scl_fall) begin
            cnt_n = 3'd0;
            if (rw) begin
              shift_n  = tx_data;
              tx_req_n = 1'b1;
              drive_n  = ~tx_data[7];
              state_n  = RD_DATA;
            end else begin
              drive_n = 1'b0;
              state_n = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shift_n = byte_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data_n   = byte_in;
              rx_valid_n  = 1'b1;
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            drive_n     = 1'b1;
            byte_done_n = 1'b0;
            state_n     = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            drive_n = 1'b0;
            cnt_n   = 3'd0;
            state_n = WR_DATA;
          end
        end

        RD_DATA: begin
          // Bit 7 went out on entry; each falling edge advances one bit and
          // the eighth hands SDA back to the master for its ACK.
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              drive_n = 1'b0;
              cnt_n   = 3'd0;
              state_n = RD_ACK;
            end else begin
              shift_n = {shift[6:0], 1'b0};
              drive_n = ~shift[6];
              cnt_n   = cnt + 3'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && !byte_done) begin
            if (!sda_s) begin
              byte_done_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            shift_n     = tx_data;
            tx_req_n    = 1'b1;
            drive_n     = ~tx_data[7];
            cnt_n       = 3'd0;
            state_n     = RD_DATA;
          end
        end

        IGNORE: begin
          drive_n = 1'b0;
        end

        default: begin
          state_n = IDLE;
          drive_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed and randomized bus transactions against the I2C target
module tb_i2c_slave;

  localparam int Q = 80;
  localparam logic [6:0] OWN_ADDR = 7'h42;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda_bus;
  wire  [7:0] rx_data;
  wire        rx_valid, tx_req, rw, busy;

  int total = 0;
  int fails = 0;

  int rxv_cnt = 0;
  int txr_cnt = 0;
  int both_cnt = 0;
  int dut_low_cnt = 0;
  int busy_cyc = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(OWN_ADDR), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rw       (rw),
    .busy     (busy)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_req) txr_cnt++;
    if (rx_valid && tx_req) both_cnt++;
    if (!m_low && sda_bus === 1'b0) dut_low_cnt++;
    if (busy) busy_cyc++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the target answers only its own address.
  function automatic logic model_ack(input logic [6:0] a);
    return a == OWN_ADDR;
  endfunction

  task automatic send_bit(input logic b, output logic s);
    m_low = ~b;
    #Q; scl = 1'b1;
    #Q; s = sda_bus;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b1;
    #Q; scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #Q; scl = 1'b1;
    #Q; m_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic [7:0] next_tx, input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    send_bit(nack, s);
  endtask

  initial begin
    logic       ack, ack2;
    logic [7:0] d, t0, t1, rb;
    logic [6:0] a;
    logic       s;
    int         rx0, tx0, low0, busy0;

    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_tx_req", tx_req, 1'b0);
    chk("reset_rw", rw, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sda", sda_bus, 1'b1);

    // 1: write to own address
    d = 8'hA5;
    rx0 = rxv_cnt; busy0 = busy_cyc;
    i2c_start();
    write_byte({OWN_ADDR, 1'b0}, ack);
    chk("t1_addr_ack", ack, 1'b1);
    write_byte(d, ack);
    chk("t1_data_ack", ack, 1'b1);
    i2c_stop();
    #Q;
    chk("t1_rx_valid_cnt", rxv_cnt - rx0, 1);
    chk("t1_rx_data", rx_data, d);
    chk("t1_busy_seen", busy_cyc != busy0, 1'b1);
    chk("t1_busy_after_stop", busy, 1'b0);

    // 2: write to a foreign address
    rx0 = rxv_cnt; busy0 = busy_cyc; low0 = dut_low_cnt;
    i2c_start();
    write_byte({7'h43, 1'b0}, ack);
    chk("t2_addr_nack", ack, 1'b0);
    write_byte(8'h11, ack);
    chk("t2_data_nack", ack, 1'b0);
    i2c_stop();
    #Q;
    chk("t2_sda_never_low", dut_low_cnt - low0, 0);
    chk("t2_no_rx_valid", rxv_cnt - rx0, 0);
    chk("t2_busy_never", busy_cyc - busy0, 0);

    // 3: two-byte read, master ACK then NACK
    t0 = 8'h3C; t1 = 8'hF0;
    tx0 = txr_cnt;
    tx_data = t0;
    i2c_start();
    write_byte({OWN_ADDR, 1'b1}, ack);
    chk("t3_addr_ack", ack, 1'b1);
    chk("t3_rw", rw, 1'b1);
    read_byte(t1, 1'b0, rb);
    chk("t3_byte0", rb, t0);
    read_byte(8'h00, 1'b1, rb);
    chk("t3_byte1", rb, t1);
    chk("t3_sda_released", sda_bus, 1'b1);
    chk("t3_busy_after_nack", busy, 1'b0);
    i2c_stop();
    #Q;
    chk("t3_tx_req_cnt", txr_cnt - tx0, 2);

    // 4: write, repeated START, read
    t0 = 8'($urandom);
    i2c_start();
    write_byte({OWN_ADDR, 1'b0}, ack);
    write_byte(8'h01, ack2);
    chk("t4_write_acks", {ack, ack2}, 2'b11);
    chk("t4_rx_data", rx_data, 8'h01);
    chk("t4_rw_write", rw, 1'b0);
    tx_data = t0;
    i2c_start();
    write_byte({OWN_ADDR, 1'b1}, ack);
    chk("t4_read_addr_ack", ack, 1'b1);
    chk("t4_rw_read", rw, 1'b1);
    read_byte(8'h00, 1'b1, rb);
    chk("t4_read_byte", rb, t0);
    i2c_stop();
    #Q;

    // 5: STOP in the middle of a data byte
    rx0 = rxv_cnt;
    d = 8'($urandom);
    i2c_start();
    write_byte({OWN_ADDR, 1'b0}, ack);
    chk("t5_addr_ack", ack, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(d[i], s);
    i2c_stop();
    #Q;
    chk("t5_no_rx_valid", rxv_cnt - rx0, 0);
    chk("t5_sda_released", sda_bus, 1'b1);
    chk("t5_busy", busy, 1'b0);

    // 6: reset while the target holds the address ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(d[i] ^ 1'b0, s) ;
    // the byte above is arbitrary; resend a proper address frame below
    i2c_start();
    begin
      logic [7:0] ab;
      ab = {OWN_ADDR, 1'b0};
      for (int i = 7; i >= 0; i--) send_bit(ab[i], s);
    end
    m_low = 1'b0;
    #Q; scl = 1'b1;
    #Q;
    chk("t6_ack_driven", sda_bus, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_sda_released", sda_bus, 1'b1);
    chk("t6_outputs", {rx_data, rx_valid, tx_req, rw, busy}, 12'h000);
    reset = 1'b0;
    #Q; scl = 1'b0;
    #Q;
    i2c_stop();
    #Q;
    d = 8'($urandom);
    i2c_start();
    write_byte({OWN_ADDR, 1'b0}, ack);
    write_byte(d, ack2);
    i2c_stop();
    #Q;
    chk("t6_post_reset_acks", {ack, ack2}, 2'b11);
    chk("t6_post_reset_rx", rx_data, d);

    // Randomized writes checked against the address model.
    for (int n = 0; n < 6; n++) begin
      logic [7:0] prev_rx;
      a = ($urandom_range(0, 1) == 0) ? OWN_ADDR : 7'($urandom);
      d = 8'($urandom);
      prev_rx = rx_data;
      rx0 = rxv_cnt;
      i2c_start();
      write_byte({a, 1'b0}, ack);
      write_byte(d, ack2);
      i2c_stop();
      #Q;
      chk($sformatf("rnd%0d_addr_ack", n), ack, model_ack(a));
      chk($sformatf("rnd%0d_data_ack", n), ack2, model_ack(a));
      chk($sformatf("rnd%0d_rx_cnt", n), rxv_cnt - rx0, model_ack(a) ? 1 : 0);
      chk($sformatf("rnd%0d_rx_data", n), rx_data, model_ack(a) ? d : prev_rx);
    end

    chk("never_rx_valid_and_tx_req", both_cnt, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
